// File: rtl/viterbi_bm_sched.sv
// viterbi_bm_sched: frame scheduler and branch metric stage for the Viterbi ACS array.
// Ports: clk/rst (sync, active-high); sym_* valid/ready symbol input with frame start
//   qualifier and three 4-bit soft bits; acs_ready backpressure; bm_* registered metric
//   set (8 x 6-bit) with valid/first/last/tail flags; busy; sticky sync_err.
module viterbi_bm_sched #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2,
  parameter int CNT_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic        sym_start,
  input  logic [3:0]  yn_in0,
  input  logic [3:0]  yn_in1,
  input  logic [3:0]  yn_in2,
  input  logic        acs_ready,
  output logic        bm_valid,
  output logic        bm_first,
  output logic        bm_last,
  output logic        bm_tail,
  output logic [47:0] bm_out,
  output logic        busy,
  output logic        sync_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  localparam bit HAS_TAIL = (TAIL_LEN > 0);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST =
    CNT_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bm_valid_q, bm_valid_d;
  logic             bm_first_q, bm_first_d;
  logic             bm_last_q, bm_last_d;
  logic             bm_tail_q, bm_tail_d;
  logic [47:0]      bm_out_q, bm_out_d;
  logic             sync_err_q, sync_err_d;

  logic        adv;
  logic        rdy;
  logic        acc;
  logic        step;
  logic        st_first;
  logic        st_last;
  logic        st_tail;
  logic [5:0]  y0, y1, y2;
  logic [47:0] metrics;

  // Codeword bit i selects +y_i or -y_i; the 24 offset keeps results in 0..48.
  function automatic logic [5:0] metric(
    input logic [2:0] k,
    input logic [5:0] a,
    input logic [5:0] b,
    input logic [5:0] c
  );
    logic [5:0] s;
    s = 6'd24;
    s = k[0] ? s + a : s - a;
    s = k[1] ? s + b : s - b;
    s = k[2] ? s + c : s - c;
    return s;
  endfunction

  always_comb begin
    adv = !bm_valid_q || acs_ready;
    rdy = adv && (state_q != S_TAIL);
    acc = sym_valid && rdy;

    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_err_q;
    step       = 1'b0;
    st_first   = 1'b0;
    st_last    = 1'b0;
    st_tail    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (sym_start) begin
            step     = 1'b1;
            st_first = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = S_RUN;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (acc) begin
          step = 1'b1;
          if (sym_start) sync_err_d = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (HAS_TAIL) begin
              state_d = S_TAIL;
            end else begin
              st_last = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (adv) begin
          step    = 1'b1;
          st_tail = 1'b1;
          if (cnt_q == TAIL_LAST) begin
            st_last = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Tail steps are erasures: zero soft input.
    if (state_q == S_TAIL) begin
      y0 = '0;
      y1 = '0;
      y2 = '0;
    end else begin
      y0 = {{2{yn_in0[3]}}, yn_in0};
      y1 = {{2{yn_in1[3]}}, yn_in1};
      y2 = {{2{yn_in2[3]}}, yn_in2};
    end

    metrics = '0;
    for (int k = 0; k < 8; k++) begin
      metrics[6*k +: 6] = metric(3'(k), y0, y1, y2);
    end

    bm_valid_d = bm_valid_q;
    bm_first_d = bm_first_q;
    bm_last_d  = bm_last_q;
    bm_tail_d  = bm_tail_q;
    bm_out_d   = bm_out_q;
    if (adv) begin
      bm_valid_d = step;
      if (step) begin
        bm_first_d = st_first;
        bm_last_d  = st_last;
        bm_tail_d  = st_tail;
        bm_out_d   = metrics;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bm_valid_q <= 1'b0;
      bm_first_q <= 1'b0;
      bm_last_q  <= 1'b0;
      bm_tail_q  <= 1'b0;
      bm_out_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bm_valid_q <= bm_valid_d;
      bm_first_q <= bm_first_d;
      bm_last_q  <= bm_last_d;
      bm_tail_q  <= bm_tail_d;
      bm_out_q   <= bm_out_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sym_ready = rdy;
  assign bm_valid  = bm_valid_q;
  assign bm_first  = bm_first_q;
  assign bm_last   = bm_last_q;
  assign bm_tail   = bm_tail_q;
  assign bm_out    = bm_out_q;
  assign busy      = (state_q != S_IDLE);
  assign sync_err  = sync_err_q;

endmodule
